sga_game_ctrl: RTL and testbench

- Parametrised next-generation control unit for the Snake Game Arcade.
- Implements the full play loop: start, initial apple, per-segment render, timed move, compare, eat/grow/new apple, collision loss, win at maximum size, and pause/resume.
- Owns the snake-size counter and the render-index counter internally.
- Talks to the apple generator and the render datapath through valid/ack handshakes.

---
 rtl/sga_pkg.sv | 52 +++++
 rtl/sga_game_ctrl_if.sv | 38 +++
 rtl/sga_render_seq.sv | 35 +++
 rtl/sga_game_ctrl.sv | 100 ++++++++++
 tb/tb_sga_game_ctrl.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sga_pkg.sv
// Shared constants, state codes and output decode for the Snake Game Arcade control unit.
package sga_pkg;

  localparam int unsigned SizeWDefault    = 6;
  localparam int unsigned MaxSizeDefault  = 36;
  localparam int unsigned InitSizeDefault = 1;

  // Enumerator values double as the db_state display codes.
  typedef enum logic [4:0] {
    StIdle            = 5'h00,
    StPrepara         = 5'h01,
    StGeraMacaInicial = 5'h02,
    StRenderiza       = 5'h03,
    StEspera          = 5'h04,
    StRegistra        = 5'h05,
    StMove            = 5'h06,
    StCompara         = 5'h07,
    StComeuMaca       = 5'h08,
    StCresce          = 5'h09,
    StGeraMaca        = 5'h0A,
    StPausou          = 5'h0B,
    StFezNada         = 5'h0C,
    StPerdeu          = 5'h0D,
    StGanhou          = 5'h0E
  } state_e;

  typedef struct packed {
    logic       apple_req;
    logic       register_dir;
    logic       move;
    logic       paused;
    logic       won;
    logic       lost;
    logic       finished;
    logic [4:0] db_state;
  } ctrl_out_t;

  function automatic ctrl_out_t decode_outputs(state_e st);
    ctrl_out_t o;
    o              = '0;
    o.db_state     = st;
    o.apple_req    = (st == StGeraMacaInicial) || (st == StGeraMaca);
    o.register_dir = (st == StRegistra);
    o.move         = (st == StMove);
    o.paused       = (st == StPausou);
    o.won          = (st == StGanhou);
    o.lost         = (st == StPerdeu);
    o.finished     = (st == StGanhou) || (st == StPerdeu);
    return o;
  endfunction

endpackage

// File: rtl/sga_game_ctrl_if.sv
// Handshake and status bundle between the game controller and its datapath/apple generator.
interface sga_game_ctrl_if #(
  parameter int unsigned SIZE_W = 6
);
  logic              start;
  logic              pause;
  logic              end_play_time;
  logic              is_at_apple;
  logic              is_at_border;
  logic              is_at_body;
  logic              apple_ack;
  logic              render_ready;
  logic              apple_req;
  logic              register_dir;
  logic              move;
  logic              render_valid;
  logic [SIZE_W-1:0] render_addr;
  logic [SIZE_W-1:0] size;
  logic              paused;
  logic              won;
  logic              lost;
  logic              finished;
  logic [4:0]        db_state;

  modport master (
    input  start, pause, end_play_time, is_at_apple, is_at_border, is_at_body,
           apple_ack, render_ready,
    output apple_req, register_dir, move, render_valid, render_addr, size,
           paused, won, lost, finished, db_state
  );

  modport slave (
    output start, pause, end_play_time, is_at_apple, is_at_border, is_at_body,
           apple_ack, render_ready,
    input  apple_req, register_dir, move, render_valid, render_addr, size,
           paused, won, lost, finished, db_state
  );
endinterface

// File: rtl/sga_render_seq.sv
// Render index sequencer: walks segments 0..size-1, one per accepted cycle.
module sga_render_seq #(
  parameter int unsigned SIZE_W = 6
) (
  input  logic              clock,
  input  logic              restart,
  input  logic              enable,
  input  logic              clear,
  input  logic              ready,
  input  logic [SIZE_W-1:0] size,
  output logic              valid,
  output logic [SIZE_W-1:0] addr,
  output logic              last
);
  logic              valid_q;
  logic [SIZE_W-1:0] addr_q;

  assign valid = valid_q;
  assign addr  = addr_q;
  assign last  = (addr_q == (size - SIZE_W'(1)));

  always_ff @(posedge clock or negedge restart) begin
    if (!restart) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
    end else begin
      valid_q <= enable;
      if (clear) begin
        addr_q <= '0;
      end else if (valid_q && ready && !last) begin
        addr_q <= addr_q + SIZE_W'(1);
      end
    end
  end
endmodule

// File: rtl/sga_game_ctrl.sv
// Snake Game Arcade play-loop controller: apple, render, move, compare, grow, win/lose, pause.
module sga_game_ctrl
  import sga_pkg::*;
#(
  parameter int unsigned SIZE_W    = SizeWDefault,
  parameter int unsigned MAX_SIZE  = MaxSizeDefault,
  parameter int unsigned INIT_SIZE = InitSizeDefault,
  parameter int unsigned WRAP_MODE = 0
) (
  input logic             clock,
  input logic             restart,
  sga_game_ctrl_if.master bus
);
  localparam logic [SIZE_W-1:0] InitSz  = SIZE_W'(INIT_SIZE);
  localparam logic [SIZE_W-1:0] MaxSz   = SIZE_W'(MAX_SIZE);
  localparam logic [SIZE_W-1:0] MaxLast = SIZE_W'(MAX_SIZE - 1);

  state_e            state_q, state_d;
  ctrl_out_t         out_q;
  logic [SIZE_W-1:0] size_q;
  logic              rs_valid, rs_last, rs_enable, rs_clear, seg_done, hit;
  logic [SIZE_W-1:0] rs_addr;

  assign seg_done  = rs_valid & bus.render_ready & rs_last;
  assign hit       = bus.is_at_body | (bus.is_at_border & (WRAP_MODE == 0));
  assign rs_enable = (state_d == StRenderiza);
  // Every entry into RENDERIZA restarts the redraw from segment 0.
  assign rs_clear  = rs_enable & (state_q != StRenderiza);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:            if (bus.start) state_d = StPrepara;
      StPrepara:         state_d = StGeraMacaInicial;
      StGeraMacaInicial: if (bus.apple_ack) state_d = StRenderiza;
      StGeraMaca:        if (bus.apple_ack) state_d = StRenderiza;
      StRenderiza:       if (seg_done) state_d = StEspera;
      StEspera: begin
        if (bus.pause)              state_d = StPausou;
        else if (bus.end_play_time) state_d = StRegistra;
      end
      StRegistra:        state_d = StMove;
      StMove:            state_d = StCompara;
      StCompara: begin
        if (hit)                  state_d = StPerdeu;
        else if (bus.is_at_apple) state_d = StComeuMaca;
        else                      state_d = StFezNada;
      end
      StComeuMaca:       state_d = StCresce;
      StCresce:          state_d = (size_q == MaxLast) ? StGanhou : StGeraMaca;
      StFezNada:         state_d = StRenderiza;
      StPausou:          if (bus.start && !bus.pause) state_d = StRenderiza;
      StPerdeu, StGanhou: if (bus.start) state_d = StPrepara;
      default:           state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they track state_q exactly.
  always_ff @(posedge clock or negedge restart) begin
    if (!restart) begin
      state_q <= StIdle;
      out_q   <= '0;
      size_q  <= InitSz;
    end else begin
      state_q <= state_d;
      out_q   <= decode_outputs(state_d);
      if (state_d == StPrepara) begin
        size_q <= InitSz;
      end else if (state_q == StCresce && size_q != MaxSz) begin
        size_q <= size_q + SIZE_W'(1);
      end
    end
  end

  sga_render_seq #(
    .SIZE_W (SIZE_W)
  ) u_render_seq (
    .clock   (clock),
    .restart (restart),
    .enable  (rs_enable),
    .clear   (rs_clear),
    .ready   (bus.render_ready),
    .size    (size_q),
    .valid   (rs_valid),
    .addr    (rs_addr),
    .last    (rs_last)
  );

  assign bus.apple_req    = out_q.apple_req;
  assign bus.register_dir = out_q.register_dir;
  assign bus.move         = out_q.move;
  assign bus.paused       = out_q.paused;
  assign bus.won          = out_q.won;
  assign bus.lost         = out_q.lost;
  assign bus.finished     = out_q.finished;
  assign bus.db_state     = out_q.db_state;
  assign bus.size         = size_q;
  assign bus.render_valid = rs_valid;
  assign bus.render_addr  = rs_addr;
endmodule

// File: tb/tb_sga_game_ctrl.sv
// Directed bench: dut0 (MAX 36, INIT 3, no wrap), dut1 (MAX 4, INIT 3, wrap).
module tb_sga_game_ctrl;
  logic clock;
  logic rst0, rst1;
  int   total = 0;
  int   bad   = 0;

  // Input vector bits: {start, pause, end_play_time, apple, border, body, apple_ack, render_ready}
  localparam logic [7:0] S = 8'h80, P = 8'h40, E = 8'h20, A = 8'h10;
  localparam logic [7:0] B = 8'h08, Y = 8'h04, K = 8'h02, R = 8'h01;

  sga_game_ctrl_if #(.SIZE_W(6)) if0 ();
  sga_game_ctrl_if #(.SIZE_W(6)) if1 ();

  sga_game_ctrl #(
    .SIZE_W(6), .MAX_SIZE(36), .INIT_SIZE(3), .WRAP_MODE(0)
  ) dut0 (
    .clock   (clock),
    .restart (rst0),
    .bus     (if0.master)
  );

  sga_game_ctrl #(
    .SIZE_W(6), .MAX_SIZE(4), .INIT_SIZE(3), .WRAP_MODE(1)
  ) dut1 (
    .clock   (clock),
    .restart (rst1),
    .bus     (if1.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_in(input int d, input logic [7:0] v);
    if (d == 0) begin
      {if0.start, if0.pause, if0.end_play_time, if0.is_at_apple, if0.is_at_border,
       if0.is_at_body, if0.apple_ack, if0.render_ready} = v;
    end else begin
      {if1.start, if1.pause, if1.end_play_time, if1.is_at_apple, if1.is_at_border,
       if1.is_at_body, if1.apple_ack, if1.render_ready} = v;
    end
  endtask

  function automatic logic [4:0] get_db(input int d);
    return (d == 0) ? if0.db_state : if1.db_state;
  endfunction

  task automatic wait_state(input int d, input logic [4:0] code, input int budget,
                            input string tag);
    for (int i = 0; i < budget && get_db(d) != code; i++) step();
    chk(tag, get_db(d), code);
  endtask

  task automatic go_espera(input int d);
    set_in(d, S | R);
    step();
    set_in(d, R);
    step();
    set_in(d, K | R);
    step();
    set_in(d, R);
    wait_state(d, 5'h4, 20, "reach_espera");
  endtask

  initial begin
    rst0 = 1'b0;
    rst1 = 1'b0;
    set_in(0, 8'h00);
    set_in(1, 8'h00);
    #12;
    chk("rst_db", if0.db_state, 5'h0);
    chk("rst_size", if0.size, 6'd3);
    chk("rst_addr", if0.render_addr, 6'd0);
    chk("rst_valid", if0.render_valid, 1'b0);
    chk("rst_apple_req", if0.apple_req, 1'b0);
    chk("rst_finished", if0.finished, 1'b0);
    rst0 = 1'b1;
    rst1 = 1'b1;
    step();

    // Start, initial apple acked after 3 cycles, first render of 3 segments
    set_in(0, S | R);
    step();
    chk("prepara", if0.db_state, 5'h1);
    set_in(0, R);
    step();
    chk("gera_ini", if0.db_state, 5'h2);
    chk("apple_req_1", if0.apple_req, 1'b1);
    step();
    step();
    chk("apple_req_hold", if0.apple_req, 1'b1);
    set_in(0, K | R);
    step();
    chk("render_enter", if0.db_state, 5'h3);
    chk("apple_req_drop", if0.apple_req, 1'b0);
    chk("render_valid", if0.render_valid, 1'b1);
    chk("addr0", if0.render_addr, 6'd0);
    set_in(0, R);
    step();
    chk("addr1", if0.render_addr, 6'd1);
    step();
    chk("addr2", if0.render_addr, 6'd2);
    step();
    chk("espera", if0.db_state, 5'h4);
    chk("valid_off", if0.render_valid, 1'b0);

    // Eat and grow, render 4 segments with stalls
    set_in(0, E | A | R);
    step();
    chk("registra", if0.db_state, 5'h5);
    chk("register_dir", if0.register_dir, 1'b1);
    set_in(0, A | R);
    step();
    chk("move_st", if0.db_state, 5'h6);
    chk("move_pulse", if0.move, 1'b1);
    chk("register_dir_off", if0.register_dir, 1'b0);
    step();
    chk("compara", if0.db_state, 5'h7);
    chk("move_off", if0.move, 1'b0);
    step();
    chk("comeu", if0.db_state, 5'h8);
    set_in(0, R);
    step();
    chk("cresce", if0.db_state, 5'h9);
    chk("size_pre", if0.size, 6'd3);
    step();
    chk("gera_maca", if0.db_state, 5'hA);
    chk("size_grow", if0.size, 6'd4);
    chk("apple_req_2", if0.apple_req, 1'b1);
    step();
    chk("apple_req_wait", if0.apple_req, 1'b1);
    set_in(0, K);
    step();
    chk("rend2_addr0", if0.render_addr, 6'd0);
    set_in(0, 8'h00);
    step();
    chk("stall_addr0", if0.render_addr, 6'd0);
    set_in(0, R);
    step();
    chk("rend2_addr1", if0.render_addr, 6'd1);
    set_in(0, 8'h00);
    step();
    chk("stall_addr1", if0.render_addr, 6'd1);
    set_in(0, R);
    step();
    chk("rend2_addr2", if0.render_addr, 6'd2);
    step();
    chk("rend2_addr3", if0.render_addr, 6'd3);
    chk("rend2_in_render", if0.db_state, 5'h3);
    step();
    chk("espera2", if0.db_state, 5'h4);

    // Second apple to size 5, pause ignored in RENDERIZA, then async abort
    set_in(0, E | A | R);
    repeat (6) step();
    chk("size5", if0.size, 6'd5);
    set_in(0, K | P | R);
    step();
    set_in(0, P | R);
    step();
    chk("pause_ign_db", if0.db_state, 5'h3);
    chk("pause_ign_addr", if0.render_addr, 6'd1);
    rst0 = 1'b0;
    #1;
    chk("abort_db", if0.db_state, 5'h0);
    chk("abort_size", if0.size, 6'd3);
    chk("abort_apple_req", if0.apple_req, 1'b0);
    chk("abort_valid", if0.render_valid, 1'b0);
    #1;
    rst0 = 1'b1;
    set_in(0, 8'h00);

    // Pause with simultaneous tick, resume rules
    go_espera(0);
    set_in(0, P | E | R);
    step();
    chk("pausou", if0.db_state, 5'hB);
    chk("paused", if0.paused, 1'b1);
    chk("no_move", if0.move, 1'b0);
    set_in(0, S | P | R);
    step();
    chk("pause_hold", if0.db_state, 5'hB);
    set_in(0, S | R);
    step();
    chk("resume_db", if0.db_state, 5'h3);
    chk("resume_addr", if0.render_addr, 6'd0);
    chk("resume_paused", if0.paused, 1'b0);
    set_in(0, R);
    wait_state(0, 5'h4, 10, "resume_espera");

    // Border collision without wrap
    set_in(0, E | B | R);
    repeat (4) step();
    chk("border_lost_db", if0.db_state, 5'hD);
    chk("border_lost", if0.lost, 1'b1);
    chk("border_finished", if0.finished, 1'b1);
    chk("border_won", if0.won, 1'b0);
    set_in(0, R);
    step();
    chk("perdeu_hold", if0.db_state, 5'hD);

    // Restart from PERDEU; apple and body together loses
    set_in(0, S | R);
    step();
    chk("restart_prepara", if0.db_state, 5'h1);
    chk("restart_size", if0.size, 6'd3);
    set_in(0, R);
    step();
    set_in(0, K | R);
    step();
    set_in(0, R);
    wait_state(0, 5'h4, 10, "restart_espera");
    set_in(0, E | A | Y | R);
    repeat (4) step();
    chk("apple_body_lost", if0.db_state, 5'hD);
    set_in(0, 8'h00);

    // dut1: wrap ignores border, then win at MAX_SIZE 4
    go_espera(1);
    set_in(1, E | B | R);
    repeat (4) step();
    chk("wrap_fez_nada", if1.db_state, 5'hC);
    set_in(1, R);
    step();
    chk("wrap_render", if1.db_state, 5'h3);
    chk("wrap_addr", if1.render_addr, 6'd0);
    wait_state(1, 5'h4, 10, "wrap_espera");
    set_in(1, E | A | R);
    repeat (5) step();
    chk("win_cresce", if1.db_state, 5'h9);
    set_in(1, R);
    step();
    chk("ganhou", if1.db_state, 5'hE);
    chk("won", if1.won, 1'b1);
    chk("won_finished", if1.finished, 1'b1);
    chk("won_lost", if1.lost, 1'b0);
    chk("won_apple_req", if1.apple_req, 1'b0);
    chk("won_size", if1.size, 6'd4);
    step();
    chk("ganhou_hold", if1.db_state, 5'hE);
    chk("ganhou_apple_req", if1.apple_req, 1'b0);
    set_in(1, S | R);
    step();
    chk("win_restart", if1.db_state, 5'h1);
    chk("win_restart_size", if1.size, 6'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
